// File: rtl/window_control_unit.sv
// Register-window control: tracks the current window pointer (cwp) and the
// window invalid mask (wim), executes SAVE/RESTORE/RETT/trap-entry window
// moves and raises overflow/underflow window traps.
// Optional build macro WINDOW_TRAP_COUNT_EN adds a saturating trap_count output.
module window_control_unit #(
  parameter int unsigned NWINDOWS = 4
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        save,
  input  logic        restore,
  input  logic        rett,
  input  logic        trap_entry,
  input  logic        cwp_we,
  input  logic [4:0]  cwp_din,
  input  logic        wim_we,
  input  logic [31:0] wim_din,
  input  logic        trap_ack,
  output logic [4:0]  cwp,
  output logic [31:0] wim,
  output logic        busy,
  output logic        done,
  output logic        trap_req,
  output logic [7:0]  trap_type
`ifdef WINDOW_TRAP_COUNT_EN
 ,output logic [15:0] trap_count
`endif
);

  localparam logic [4:0]  LastWin       = 5'(NWINDOWS - 1);
  // Only bits for implemented windows may ever be set in wim
  localparam logic [31:0] WimMask       = (NWINDOWS >= 32) ? 32'hFFFF_FFFF :
                                          ((32'd1 << NWINDOWS) - 32'd1);
  localparam logic [7:0]  TrapOverflow  = 8'h05;
  localparam logic [7:0]  TrapUnderflow = 8'h06;

  typedef enum logic [1:0] {StIdle, StCheck, StTrap} state_e;
  typedef enum logic [1:0] {OpSave, OpRestore, OpRett, OpTrapEntry} op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [4:0]  cwp_q, cwp_d;
  logic [4:0]  next_q, next_d;
  logic [31:0] wim_q, wim_d;
  logic        done_q, done_d;
  logic [7:0]  type_q, type_d;
  logic [4:0]  cwp_dec, cwp_inc;
`ifdef WINDOW_TRAP_COUNT_EN
  logic [15:0] count_q, count_d;
`endif

  // Neighbouring windows with modulo-NWINDOWS wraparound
  assign cwp_dec = (cwp_q == 5'd0) ? LastWin : cwp_q - 5'd1;
  assign cwp_inc = (cwp_q == LastWin) ? 5'd0 : cwp_q + 5'd1;

  // Next-state logic: request decode in idle, window check, trap hold
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cwp_d   = cwp_q;
    next_d  = next_q;
    wim_d   = wim_q;
    done_d  = 1'b0;
    type_d  = type_q;
`ifdef WINDOW_TRAP_COUNT_EN
    count_d = count_q;
`endif
    case (state_q)
      StIdle: begin
        // Fixed priority; lower-priority requests in the same cycle are dropped
        if (cwp_we) begin
          if ({27'd0, cwp_din} < NWINDOWS) cwp_d = cwp_din;
        end else if (wim_we) begin
          wim_d = wim_din & WimMask;
        end else if (trap_entry) begin
          next_d  = cwp_dec;
          op_d    = OpTrapEntry;
          state_d = StCheck;
        end else if (rett) begin
          next_d  = cwp_inc;
          op_d    = OpRett;
          state_d = StCheck;
        end else if (restore) begin
          next_d  = cwp_inc;
          op_d    = OpRestore;
          state_d = StCheck;
        end else if (save) begin
          next_d  = cwp_dec;
          op_d    = OpSave;
          state_d = StCheck;
        end
      end
      StCheck: begin
        // Trap entry always gets a window; the others trap on an invalid one
        if (op_q == OpTrapEntry || !wim_q[next_q]) begin
          cwp_d   = next_q;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          type_d  = (op_q == OpSave) ? TrapOverflow : TrapUnderflow;
          state_d = StTrap;
`ifdef WINDOW_TRAP_COUNT_EN
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
`endif
        end
      end
      StTrap: begin
        if (trap_ack) begin
          type_d  = 8'h00;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with asynchronous clear
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= StIdle;
      op_q    <= OpSave;
      cwp_q   <= 5'd0;
      next_q  <= 5'd0;
      wim_q   <= 32'd0;
      done_q  <= 1'b0;
      type_q  <= 8'h00;
`ifdef WINDOW_TRAP_COUNT_EN
      count_q <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cwp_q   <= cwp_d;
      next_q  <= next_d;
      wim_q   <= wim_d;
      done_q  <= done_d;
      type_q  <= type_d;
`ifdef WINDOW_TRAP_COUNT_EN
      count_q <= count_d;
`endif
    end
  end

  assign cwp       = cwp_q;
  assign wim       = wim_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign trap_req  = (state_q == StTrap);
  assign trap_type = type_q;
`ifdef WINDOW_TRAP_COUNT_EN
  assign trap_count = count_q;
`endif

endmodule

// File: tb/tb_window_control_unit.sv
// Self-checking bench for window_control_unit with NWINDOWS=4.
// A transaction-level model predicts outputs; literal checks pin key points.
module tb_window_control_unit;

  localparam int N = 4;

  logic        Clk = 1'b0;
  logic        Clr = 1'b0;
  logic        save = 1'b0, restore = 1'b0, rett = 1'b0, trap_entry = 1'b0;
  logic        cwp_we = 1'b0, wim_we = 1'b0, trap_ack = 1'b0;
  logic [4:0]  cwp_din = 5'd0;
  logic [31:0] wim_din = 32'd0;
  logic [4:0]  cwp;
  logic [31:0] wim;
  logic        busy, done, trap_req;
  logic [7:0]  trap_type;
`ifdef WINDOW_TRAP_COUNT_EN
  logic [15:0] trap_count;
`endif

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 Clk = ~Clk;

  window_control_unit #(.NWINDOWS(N)) dut (
    .Clk        (Clk),
    .Clr        (Clr),
    .save       (save),
    .restore    (restore),
    .rett       (rett),
    .trap_entry (trap_entry),
    .cwp_we     (cwp_we),
    .cwp_din    (cwp_din),
    .wim_we     (wim_we),
    .wim_din    (wim_din),
    .trap_ack   (trap_ack),
    .cwp        (cwp),
    .wim        (wim),
    .busy       (busy),
    .done       (done),
    .trap_req   (trap_req),
    .trap_type  (trap_type)
`ifdef WINDOW_TRAP_COUNT_EN
   ,.trap_count (trap_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] legal_mask();
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 32; i++) if (i < N) m[i] = 1'b1;
    return m;
  endfunction

  // Model: phase 0 = accepting requests, 1 = one cycle evaluating, 2 = trap held
  int          m_cwp, m_tgt, m_phase, m_step, m_count;
  bit          m_commit, m_done;
  logic [31:0] m_wim;
  logic [7:0]  m_type, m_pend_type;

  always @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      m_cwp = 0; m_tgt = 0; m_phase = 0; m_count = 0;
      m_commit = 1'b0; m_done = 1'b0; m_wim = 32'd0; m_type = 8'h00; m_pend_type = 8'h00;
    end else begin
      m_done = 1'b0;
      case (m_phase)
        0: begin
          if (cwp_we) begin
            if (int'(cwp_din) < N) m_cwp = int'(cwp_din);
          end else if (wim_we) begin
            m_wim = wim_din & legal_mask();
          end else if (trap_entry || rett || restore || save) begin
            // Moving down one window is the same as moving up N-1
            m_step = (trap_entry || !(rett || restore)) ? N - 1 : 1;
            m_tgt  = (m_cwp + m_step) % N;
            m_commit = trap_entry || !m_wim[m_tgt];
            m_pend_type = (!trap_entry && (rett || restore)) ? 8'h06 : 8'h05;
            m_phase = 1;
          end
        end
        1: begin
          if (m_commit) begin
            m_cwp = m_tgt; m_done = 1'b1; m_phase = 0;
          end else begin
            m_type = m_pend_type; m_phase = 2;
            if (m_count < 65535) m_count++;
          end
        end
        default: begin
          if (trap_ack) begin
            m_type = 8'h00; m_phase = 0;
          end
        end
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge Clk) begin
    if (cmp_en) begin
      check("cwp", 32'(cwp), 32'(m_cwp));
      check("wim", wim, m_wim);
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("done", 32'(done), 32'(m_done));
      check("trap_req", 32'(trap_req), 32'(m_phase == 2));
      check("trap_type", 32'(trap_type), 32'(m_type));
`ifdef WINDOW_TRAP_COUNT_EN
      check("trap_count", 32'(trap_count), 32'(m_count));
`endif
    end
  end

  task automatic clear_inputs();
    save = 1'b0; restore = 1'b0; rett = 1'b0; trap_entry = 1'b0;
    cwp_we = 1'b0; cwp_din = 5'd0; wim_we = 1'b0; wim_din = 32'd0; trap_ack = 1'b0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Drive one cycle of inputs, sampled by the next edge, then release them
  task automatic pulse(input bit s, input bit r, input bit rt, input bit te, input bit cw,
                       input logic [4:0] cd, input bit ww, input logic [31:0] wd, input bit ak);
    save = s; restore = r; rett = rt; trap_entry = te;
    cwp_we = cw; cwp_din = cd; wim_we = ww; wim_din = wd; trap_ack = ak;
    step();
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    #1 Clr = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Clr = 1'b0;
    check("reset_cwp", 32'(cwp), 32'd0);
    check("reset_wim", wim, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // save from reset: 0 -> 3 two edges later, one done pulse
    pulse(1, 0, 0, 0, 0, 5'd0, 0, 32'd0, 0);
    check("save_busy", 32'(busy), 32'd1);
    check("save_cwp_hold", 32'(cwp), 32'd0);
    step();
    check("save_cwp", 32'(cwp), 32'd3);
    check("save_done", 32'(done), 32'd1);
    check("save_no_trap", 32'(trap_req), 32'd0);
    step();
    check("save_done_clear", 32'(done), 32'd0);

    // overflow: wim=4, cwp=3, save -> trap 05 held until ack
    pulse(0, 0, 0, 0, 0, 5'd0, 1, 32'h4, 0);
    check("wim_write", wim, 32'h4);
    pulse(1, 0, 0, 0, 0, 5'd0, 0, 32'd0, 0);
    step();
    check("ovf_req", 32'(trap_req), 32'd1);
    check("ovf_type", 32'(trap_type), 32'h05);
    pulse(1, 1, 0, 0, 0, 5'd0, 0, 32'd0, 0); // ignored while trapped
    repeat (3) step();
    check("ovf_cwp_hold", 32'(cwp), 32'd3);
    check("ovf_req_hold", 32'(trap_req), 32'd1);
    pulse(0, 0, 0, 0, 0, 5'd0, 0, 32'd0, 1);
    check("ovf_ack_req", 32'(trap_req), 32'd0);
    check("ovf_ack_type", 32'(trap_type), 32'd0);
    check("ovf_ack_busy", 32'(busy), 32'd0);
    check("ovf_ack_done", 32'(done), 32'd0);
    pulse(0, 0, 0, 0, 0, 5'd0, 0, 32'd0, 1); // stray ack in idle

    // underflow via restore, then rett
    pulse(0, 0, 0, 0, 0, 5'd0, 1, 32'h1, 0);
    pulse(0, 1, 0, 0, 0, 5'd0, 0, 32'd0, 0);
    step();
    check("unf_restore_type", 32'(trap_type), 32'h06);
    check("unf_restore_cwp", 32'(cwp), 32'd3);
    pulse(0, 0, 0, 0, 0, 5'd0, 0, 32'd0, 1);
    pulse(0, 0, 1, 0, 0, 5'd0, 0, 32'd0, 0);
    step();
    check("unf_rett_type", 32'(trap_type), 32'h06);
    check("unf_rett_cwp", 32'(cwp), 32'd3);
    pulse(0, 0, 0, 0, 0, 5'd0, 0, 32'd0, 1);

    // trap_entry ignores wim
    pulse(0, 0, 0, 0, 1, 5'd1, 0, 32'd0, 0);
    check("cwp_write", 32'(cwp), 32'd1);
    pulse(0, 0, 0, 1, 0, 5'd0, 0, 32'd0, 0);
    step();
    check("te_cwp", 32'(cwp), 32'd0);
    check("te_done", 32'(done), 32'd1);
    check("te_no_trap", 32'(trap_req), 32'd0);

    // priority and range checks
    pulse(1, 1, 0, 0, 1, 5'd2, 0, 32'd0, 0);
    check("prio_cwp", 32'(cwp), 32'd2);
    check("prio_idle", 32'(busy), 32'd0);
    step();
    check("prio_no_op", 32'(cwp), 32'd2);
    pulse(0, 0, 0, 0, 1, 5'd5, 0, 32'd0, 0);
    check("cwp_range", 32'(cwp), 32'd2);
    pulse(0, 0, 0, 0, 0, 5'd0, 1, 32'hFFFF_FFFF, 0);
    check("wim_mask", wim, 32'hF);

    // restore wrap 3 -> 0, then trap_entry beats rett
    pulse(0, 0, 0, 0, 0, 5'd0, 1, 32'd0, 0);
    pulse(0, 0, 0, 0, 1, 5'd3, 0, 32'd0, 0);
    pulse(0, 1, 0, 0, 0, 5'd0, 0, 32'd0, 0);
    step();
    check("restore_wrap", 32'(cwp), 32'd0);
    pulse(0, 0, 1, 1, 0, 5'd0, 0, 32'd0, 0);
    step();
    check("te_over_rett", 32'(cwp), 32'd3);

    // Clr, two overflow traps, Clr during the second trap
    Clr = 1'b1;
    step();
    Clr = 1'b0;
    pulse(0, 0, 0, 0, 0, 5'd0, 1, 32'h1, 0);
    pulse(0, 0, 0, 0, 1, 5'd1, 0, 32'd0, 0);
    pulse(1, 0, 0, 0, 0, 5'd0, 0, 32'd0, 0);
    step();
    pulse(0, 0, 0, 0, 0, 5'd0, 0, 32'd0, 1);
    pulse(1, 0, 0, 0, 0, 5'd0, 0, 32'd0, 0);
    step();
    check("trap2_req", 32'(trap_req), 32'd1);
`ifdef WINDOW_TRAP_COUNT_EN
    check("count_two", 32'(trap_count), 32'd2);
`endif
    Clr = 1'b1;
    #1;
    check("clr_req", 32'(trap_req), 32'd0);
    check("clr_cwp", 32'(cwp), 32'd0);
    check("clr_wim", wim, 32'd0);
    check("clr_type", 32'(trap_type), 32'd0);
`ifdef WINDOW_TRAP_COUNT_EN
    check("count_clr", 32'(trap_count), 32'd0);
`endif
    step();
    Clr = 1'b0;

    // resumes on first edge after Clr release
    pulse(1, 0, 0, 0, 0, 5'd0, 0, 32'd0, 0);
    check("resume_busy", 32'(busy), 32'd1);
    step();
    check("resume_cwp", 32'(cwp), 32'd3);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
